// File: rtl/seq_pattern_gen_if.sv
// Bus bundle between a stimulus controller and the serial pattern generator.
// The master side loads patterns and starts transfers; the slave side (the
// generator) returns the serial stream plus its status and self-check flags.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] length;
    logic             start;
    logic             repeat_en;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             z_expect;

    modport master (
        output load, pattern, length, start, repeat_en,
        input  w, w_valid, busy, done, err, z_expect
    );

    modport slave (
        input  load, pattern, length, start, repeat_en,
        output w, w_valid, busy, done, err, z_expect
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter used as stimulus for the 0000/1111 recognizer.
// A parallel pattern is captured into shadow registers, then shifted out MSB
// first on w, one bit per clock. Alongside each bit it raises z_expect when w
// completes a run of four or more identical bits, which is exactly what the
// recognizer should report one clock later.
module seq_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic              clock,
    input logic              resetn,
    seq_pattern_gen_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] BIT0    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shadow;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic [2:0]       r_run;
    logic             r_w;
    logic             r_wValid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_zExpect;

    logic             w_loadLegal;
    logic [CNT_W-1:0] w_lastIdx;
    logic             w_lastBit;
    logic [CNT_W-1:0] w_nextPos;
    logic [WIDTH-1:0] w_startMask;
    logic [WIDTH-1:0] w_nextMask;
    logic             w_startBit;
    logic             w_nextBit;
    logic [2:0]       w_runInc;
    logic [2:0]       w_runNext;

    // A load is only accepted when its length fits the shadow register.
    assign w_loadLegal = (bus.length != '0) && (bus.length <= LEN_MAX);

    // r_idx names the bit currently on w; the last bit of a pass is len-1.
    assign w_lastIdx = r_len - CNT_W'(1);
    assign w_lastBit = (r_idx == w_lastIdx);

    // Pattern position of the bit that goes out next: the field MSB again
    // after a wrap, otherwise one position lower than the current bit.
    assign w_nextPos = w_lastBit ? w_lastIdx : (w_lastIdx - r_idx - CNT_W'(1));

    // Bit selection by mask so every shadow bit feeds the mux.
    assign w_startMask = BIT0 << w_lastIdx;
    assign w_nextMask  = BIT0 << w_nextPos;
    assign w_startBit  = |(r_shadow & w_startMask);
    assign w_nextBit   = |(r_shadow & w_nextMask);

    // Run length of identical bits, saturating at four; it compares the next
    // bit against the one on w now, so it carries straight across a wrap.
    assign w_runInc  = (r_run == 3'd4) ? 3'd4 : (r_run + 3'd1);
    assign w_runNext = (w_nextBit == r_w) ? w_runInc : 3'd1;

    // Main controller: every output is a register updated from the next state,
    // so the first bit shows on w in the cycle right after start is sampled.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_shadow  <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_run     <= 3'd0;
            r_w       <= 1'b0;
            r_wValid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_zExpect <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOADED: begin
                    if (bus.load) begin
                        if (w_loadLegal) begin
                            r_shadow <= bus.pattern;
                            r_len    <= bus.length;
                            r_state  <= ST_LOADED;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (bus.start && (r_state == ST_LOADED)) begin
                        r_state   <= ST_SEND;
                        r_idx     <= '0;
                        r_w       <= w_startBit;
                        r_wValid  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_run     <= 3'd1;
                        r_zExpect <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_lastBit && !bus.repeat_en) begin
                        r_state   <= ST_DONE;
                        r_idx     <= '0;
                        r_w       <= 1'b0;
                        r_wValid  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_run     <= 3'd0;
                        r_zExpect <= 1'b0;
                    end else begin
                        r_idx     <= w_lastBit ? '0 : (r_idx + CNT_W'(1));
                        r_w       <= w_nextBit;
                        r_run     <= w_runNext;
                        r_zExpect <= (w_runNext >= 3'd4);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_LOADED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.w        = r_w;
    assign bus.w_valid  = r_wValid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.z_expect = r_zExpect;

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: loads a parallel bit pattern, then drives it one bit per clock onto a serial line `w`, MSB first.
- Feeds the 0000/1111 sequence-recognizer FSM. Used as its on-board stimulus source in place of hand-toggling the `w` switch.
- Also produces `z_expect`, the run-of-four flag the recognizer must raise one clock after each bit, for self-checking on LEDs.

Parameters:
- WIDTH, default 16: pattern register width in bits.
- CNT_W, default 5: width of the length and index fields. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  — the single clock. All logic is posedge-triggered.
- resetn  input  1  — synchronous, active-low reset, sampled on the posedge of clock.
- load  input  1  — capture `pattern`/`length` into the shadow registers.
- pattern  input  WIDTH  — bits to send. Only the low `length` bits are used.
- length  input  CNT_W  — number of bits per pass. Legal range is 1..WIDTH.
- start  input  1  — begin transmission of the shadow pattern.
- repeat_en  input  1  — loop the pattern continuously instead of sending one pass.
- w  output  1  — serial data out, registered.
- w_valid  output  1  — high while `w` carries pattern data.
- busy  output  1  — high in SEND.
- done  output  1  — one-cycle pulse after the final bit.
- err  output  1  — one-cycle pulse when a load is rejected.
- z_expect  output  1  — high in any cycle where `w` completes a run of ≥4 identical bits.

Behaviour:
- Reset:
  - While resetn=0 at a posedge: state=IDLE.
  - w=0, w_valid=0, busy=0, done=0, err=0, z_expect=0.
  - Shadow pattern=0, shadow length=0, idx=0, run=0.
  - Reset during SEND aborts the transfer immediately. No done pulse is issued.
- States: IDLE, LOADED, SEND, DONE. All outputs are registered.
- IDLE:
  - load=1 with 1≤length≤WIDTH: capture pattern and length, go to LOADED.
  - load=1 with length=0 or length>WIDTH: err=1 for one cycle, stay in IDLE, shadow unchanged.
  - start is ignored.
- LOADED:
  - A legal load replaces the shadow; an illegal load pulses err and keeps the old shadow. Either way, stay in LOADED.
  - start=1 with load=0: go to SEND with idx=0.
  - load and start in the same cycle: load wins, start is ignored.
- SEND:
  - Each cycle, w = shadow[len-1-idx] (MSB of the field first), w_valid=1, busy=1.
  - Latency: the first bit appears on w in the first cycle after start is sampled.
  - idx increments every cycle.
  - At idx=len-1, repeat_en is sampled in that same cycle:
    - repeat_en=1: idx wraps to 0 and the next pass follows with no gap.
    - repeat_en=0: go to DONE.
  - Clearing repeat_en mid-pass lets the current pass finish.
  - load and start are ignored in SEND.
- DONE (one cycle):
  - done=1, w_valid=0, busy=0, w=0, run cleared.
  - Next state is LOADED; the shadow is retained, so start re-sends the same pattern.
- Run tracking (SEND only):
  - run=1 on the first bit of a transfer.
  - Otherwise run=run+1 if the bit equals the previous bit, else run=1. run saturates at 4.
  - run continues across repeat wraps.
  - z_expect = w_valid & (run≥4), aligned with the same cycle as w.
- len=1 with repeat_en=1: the same bit is sent every cycle. z_expect goes high from the 4th bit on.

Test Plan:
- Basic transfer:
  - Stimulus: reset, load pattern=16'h000F, length=8, then start.
  - Required: the 8 SEND cycles show w=0,0,0,0,1,1,1,1 and z_expect=0,0,0,1,0,0,0,1.
  - Required: done pulses in the following cycle, then state returns to LOADED.
- Illegal loads: load with length=0, then with length=17.
  - Required: err pulses for one cycle each, state stays IDLE, start is ignored and w_valid stays 0.
- Repeat mode: load 2'b11, length=2, repeat_en=1, start.
  - Required: w=1 every cycle, z_expect=1 from the 4th bit onward.
  - Clear repeat_en in the 7th SEND cycle: the pass still finishes with 8 bits total, then done pulses.
- Load/start collision: in LOADED, assert load (pattern=3'b101, length=3) and start in the same cycle.
  - Required: shadow updates and no transfer begins.
  - start the next cycle gives w=1,0,1 with z_expect=0 throughout.
- Reset mid-operation: load 16'hAAAA, length=16, start, then drive resetn=0 at the 5th SEND cycle.
  - Required: on the next posedge all outputs are 0, no done pulse, state is IDLE.
  - A subsequent start is ignored until a new load.
- Re-send: after one completed pass, pulse start again without a load.
  - Required: an identical bit sequence is sent, and run restarts (z_expect is not carried over from the previous transfer).
